// File: rtl/fpnew_share_arbiter_pkg.sv
// Shared types for the FPU share arbiter: FPU enums plus default request/response
// structs sized for Width=64, ReqTagWidth=4, NumReq=4.
package fpnew_share_arbiter_pkg;

  localparam int unsigned DEF_WIDTH   = 64;
  localparam int unsigned DEF_TAG_W   = 4;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_ID_W    = $clog2(DEF_NUM_REQ);

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8, INT16, INT32, INT64
  } int_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  // Requester-side request: tag is the requester's own tag.
  typedef struct packed {
    logic [2:0][DEF_WIDTH-1:0] operands;
    roundmode_e                rnd_mode;
    operation_e                op;
    logic                      op_mod;
    fp_format_e                fp_fmt;
    fp_format_e                fp_fmt2;
    int_format_e               int_fmt;
    logic                      vectorial_op;
    logic [DEF_TAG_W-1:0]      tag;
  } fpu_req_def_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] result;
    status_t              status;
    logic [DEF_TAG_W-1:0] tag;
  } fpu_rsp_def_t;

  // FPU-side variants carry {id, req_tag}.
  typedef struct packed {
    logic [2:0][DEF_WIDTH-1:0]     operands;
    roundmode_e                    rnd_mode;
    operation_e                    op;
    logic                          op_mod;
    fp_format_e                    fp_fmt;
    fp_format_e                    fp_fmt2;
    int_format_e                   int_fmt;
    logic                          vectorial_op;
    logic [DEF_ID_W+DEF_TAG_W-1:0] tag;
  } fpu_out_req_def_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]          result;
    status_t                       status;
    logic [DEF_ID_W+DEF_TAG_W-1:0] tag;
  } fpu_out_rsp_def_t;

endpackage

// File: rtl/fpnew_share_credit.sv
// Per-requester outstanding-operation counter; inc and dec in the same cycle cancel.
module fpnew_share_credit
  import fpnew_share_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc,
  input  logic                dec,
  input  logic                clr,
  output logic                full,
  output logic                nonzero,
  output logic [CntWidth-1:0] cnt
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign full    = (cnt == CntWidth'(MaxOutstanding));
  assign nonzero = (cnt != '0);

  // A completion with nothing outstanding means the response tag was corrupted.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (dec && !inc && !clr) |-> nonzero);

endmodule

// File: rtl/fpnew_share_arbiter.sv
// Shares one FPU between NumReq requesters: round-robin with grant lock and
// per-requester credit limit on requests, tag-based routing on responses.
module fpnew_share_arbiter
  import fpnew_share_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned Width          = 64,
  parameter int unsigned ReqTagWidth    = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         fpu_req_t      = fpu_req_def_t,
  parameter type         fpu_rsp_t      = fpu_rsp_def_t,
  parameter type         fpu_out_req_t  = fpu_out_req_def_t,
  parameter type         fpu_out_rsp_t  = fpu_out_rsp_def_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fpu_req_t [NumReq-1:0]    req_i,
  input  logic     [NumReq-1:0]    req_valid_i,
  output logic     [NumReq-1:0]    req_ready_o,
  output fpu_rsp_t [NumReq-1:0]    rsp_o,
  output logic     [NumReq-1:0]    rsp_valid_o,
  input  logic     [NumReq-1:0]    rsp_ready_i,
  output fpu_out_req_t             fpu_req_o,
  output logic                     fpu_valid_o,
  input  logic                     fpu_ready_i,
  input  fpu_out_rsp_t             fpu_rsp_i,
  input  logic                     fpu_rsp_valid_i,
  output logic                     fpu_rsp_ready_o,
  output logic                     busy_o
);

  localparam int unsigned IdWidth  = $clog2(NumReq);
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [IdWidth-1:0] rr_q, gnt_q, sel, sel_rr, id;
  logic               lock_q, found, valid_raw, acc, id_ok;
  logic [NumReq-1:0]  elig, full, nonzero, dec;
  logic [NumReq-1:0][CntWidth-1:0] cnt;
  logic [Width-1:0]   fpu_result;

  assign elig = req_valid_i & ~full;

  // Priority scan starting at rr_q with wrap-around.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    sel_rr = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        sel_rr = IdWidth'(idx);
      end
    end
  end

  assign sel       = lock_q ? gnt_q : sel_rr;
  assign valid_raw = lock_q ? req_valid_i[gnt_q] : found;
  // Nothing is offered to the FPU while it is being flushed.
  assign fpu_valid_o = valid_raw && !flush_i;
  assign acc         = fpu_valid_o && fpu_ready_i;
  assign req_ready_o = acc ? (NumReq'(1) << sel) : '0;

  always_comb begin
    fpu_req_o              = '0;
    fpu_req_o.operands     = req_i[sel].operands;
    fpu_req_o.rnd_mode     = req_i[sel].rnd_mode;
    fpu_req_o.op           = req_i[sel].op;
    fpu_req_o.op_mod       = req_i[sel].op_mod;
    fpu_req_o.fp_fmt       = req_i[sel].fp_fmt;
    fpu_req_o.fp_fmt2      = req_i[sel].fp_fmt2;
    fpu_req_o.int_fmt      = req_i[sel].int_fmt;
    fpu_req_o.vectorial_op = req_i[sel].vectorial_op;
    fpu_req_o.tag          = {sel, req_i[sel].tag};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
    end else if (flush_i) begin
      lock_q <= 1'b0;
    end else if (acc) begin
      lock_q <= 1'b0;
      rr_q   <= (sel == IdWidth'(NumReq - 1)) ? '0 : sel + 1'b1;
    end else if (fpu_valid_o && !fpu_ready_i) begin
      lock_q <= 1'b1;
      gnt_q  <= sel;
    end
  end

  // Response side: the id in the upper tag bits picks the destination.
  assign id         = fpu_rsp_i.tag[IdWidth+ReqTagWidth-1 -: IdWidth];
  assign id_ok      = (32'(id) < NumReq);
  assign fpu_result = fpu_rsp_i.result;

  always_comb begin
    rsp_valid_o     = '0;
    fpu_rsp_ready_o = 1'b0;
    if (id_ok && !flush_i) begin
      rsp_valid_o[id] = fpu_rsp_valid_i;
      fpu_rsp_ready_o = rsp_ready_i[id];
    end
  end

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      rsp_o[i]        = '0;
      rsp_o[i].result = fpu_result;
      rsp_o[i].status = fpu_rsp_i.status;
      rsp_o[i].tag    = fpu_rsp_i.tag[ReqTagWidth-1:0];
    end
  end

  assign dec = rsp_valid_o & rsp_ready_i;

  for (genvar i = 0; i < NumReq; i++) begin : g_credit
    fpnew_share_credit #(
      .MaxOutstanding (MaxOutstanding),
      .CntWidth       (CntWidth)
    ) u_credit (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc     (req_ready_o[i]),
      .dec     (dec[i]),
      .clr     (flush_i),
      .full    (full[i]),
      .nonzero (nonzero[i]),
      .cnt     (cnt[i])
    );
  end

  assign busy_o = (|nonzero) || fpu_valid_o;

  // Out-of-range ids are held at the FPU output rather than dropped.
  a_valid_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fpu_rsp_valid_i |-> id_ok);

endmodule
